// File: rtl/pingpong_ctrl.sv
// Ping-pong buffer sequencer: launches a producer into the empty bank and a consumer on the
// full bank, both over ap_ctrl_chain handshakes, for a programmed number of iterations.
module pingpong_ctrl #(
  parameter int unsigned ITER_W = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic              prod_start,
  input  logic              prod_ready,
  input  logic              prod_done,
  output logic              prod_continue,
  output logic              prod_bank,
  output logic              cons_start,
  input  logic              cons_ready,
  input  logic              cons_done,
  output logic              cons_continue,
  output logic              cons_bank
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ITER_W-1:0] CntOne = {{(ITER_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ITER_W-1:0] total_q, total_d;
  logic [ITER_W-1:0] prod_cnt_q, prod_cnt_d;
  logic [ITER_W-1:0] cons_cnt_q, cons_cnt_d;
  logic              prod_act_q, prod_act_d;
  logic              cons_act_q, cons_act_d;
  logic              prod_start_q, prod_start_d;
  logic              cons_start_q, cons_start_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;

  logic clr_cnt;
  logic run;
  logic prod_launch, prod_cmp, prod_ack;
  logic cons_launch, cons_cmp, cons_ack;

  // Top-level start/done sequencing
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    clr_cnt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          total_d = num_iter;
          clr_cnt = 1'b1;
          state_d = (num_iter == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (cons_cnt_q == total_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign run = (state_q == StRun);

  // Launches only consider registered state, so a freed bank is seen one cycle after done.
  always_comb begin
    prod_launch = run & ~prod_act_q & (prod_cnt_q < total_q) & ~bank_full_q[wr_ptr_q];
    cons_launch = run & ~cons_act_q & (cons_cnt_q < total_q) & bank_full_q[rd_ptr_q];
    prod_cmp    = prod_act_q & prod_done;
    cons_cmp    = cons_act_q & cons_done;
    prod_ack    = prod_start_q & prod_ready;
    cons_ack    = cons_start_q & cons_ready;
  end

  always_comb begin
    prod_start_d = prod_start_q;
    prod_act_d   = prod_act_q;
    if (prod_launch) begin
      prod_start_d = 1'b1;
      prod_act_d   = 1'b1;
    end else begin
      if (prod_ack || prod_cmp) prod_start_d = 1'b0;
      if (prod_cmp)             prod_act_d   = 1'b0;
    end

    cons_start_d = cons_start_q;
    cons_act_d   = cons_act_q;
    if (cons_launch) begin
      cons_start_d = 1'b1;
      cons_act_d   = 1'b1;
    end else begin
      if (cons_ack || cons_cmp) cons_start_d = 1'b0;
      if (cons_cmp)             cons_act_d   = 1'b0;
    end
  end

  // Producer and consumer always own opposite banks, so both updates can land in one edge.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (prod_cmp) begin
      bank_full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (cons_cmp) begin
      bank_full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d              = ~rd_ptr_q;
    end
  end

  always_comb begin
    prod_cnt_d = prod_cnt_q;
    cons_cnt_d = cons_cnt_q;
    if (clr_cnt) begin
      prod_cnt_d = '0;
      cons_cnt_d = '0;
    end else begin
      if (prod_cmp) prod_cnt_d = prod_cnt_q + CntOne;
      if (cons_cmp) cons_cnt_d = cons_cnt_q + CntOne;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      total_q      <= '0;
      prod_cnt_q   <= '0;
      cons_cnt_q   <= '0;
      prod_act_q   <= 1'b0;
      cons_act_q   <= 1'b0;
      prod_start_q <= 1'b0;
      cons_start_q <= 1'b0;
      bank_full_q  <= 2'b00;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      prod_cnt_q   <= prod_cnt_d;
      cons_cnt_q   <= cons_cnt_d;
      prod_act_q   <= prod_act_d;
      cons_act_q   <= cons_act_d;
      prod_start_q <= prod_start_d;
      cons_start_q <= cons_start_d;
      bank_full_q  <= bank_full_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Continue mirrors done so the sub-blocks never hold a pending done.
  assign prod_continue = prod_done;
  assign cons_continue = cons_done;
  assign prod_start    = prod_start_q;
  assign cons_start    = cons_start_q;
  assign prod_bank     = wr_ptr_q;
  assign cons_bank     = rd_ptr_q;
  assign ap_done       = (state_q == StDone);
  assign ap_ready      = ap_done;
  assign ap_idle       = (state_q == StIdle) & ~ap_start;

endmodule
